// File: rtl/canvas_arbiter_pkg.sv
// Shared constants and types for the canvas arbiter: canvas geometry,
// recognizer timeout and the arbiter state encoding.
package canvas_pkg;

    localparam int CANVAS_ADDR_W = 10;
    localparam int CANVAS_PIXELS = 1 << CANVAS_ADDR_W;
    localparam int REC_TIMEOUT   = 2047;
    localparam int REC_DATA_W    = 8;
    localparam int GRID_W        = CANVAS_ADDR_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_START = 2'd2,
        ST_RECOG = 2'd3
    } state_e;

    // Row occupies the upper half of the address, column the lower half.
    function automatic logic [CANVAS_ADDR_W-1:0] pixel_addr(
        input logic [GRID_W-1:0] row,
        input logic [GRID_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/canvas_arbiter_if.sv
// Bundle of the pen, user, recognizer and canvas-RAM signals around the arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface canvas_arbiter_if
    import canvas_pkg::*;
#(
    parameter int ADDR_W = CANVAS_ADDR_W
);

    logic                  draw_req;
    logic [ADDR_W-1:0]     draw_addr;
    logic                  draw_data;
    logic                  draw_ack;

    logic                  submit;
    logic                  clear_req;
    logic                  end_write;

    logic                  rec_read_enable;
    logic [ADDR_W-1:0]     rec_read_addr;
    logic                  rec_read_data;
    logic                  rec_ready;
    logic [REC_DATA_W-1:0] rec_data;

    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic                  mem_wdata;
    logic                  mem_rdata;

    logic                  busy;
    logic [REC_DATA_W-1:0] result;
    logic                  result_valid;
    logic                  timeout_err;

    modport slave (
        input  draw_req, draw_addr, draw_data,
        input  submit, clear_req,
        input  rec_read_enable, rec_read_addr, rec_ready, rec_data,
        input  mem_rdata,
        output draw_ack, end_write, rec_read_data,
        output mem_addr, mem_we, mem_wdata,
        output busy, result, result_valid, timeout_err
    );

    modport master (
        output draw_req, draw_addr, draw_data,
        output submit, clear_req,
        output rec_read_enable, rec_read_addr, rec_ready, rec_data,
        output mem_rdata,
        input  draw_ack, end_write, rec_read_data,
        input  mem_addr, mem_we, mem_wdata,
        input  busy, result, result_valid, timeout_err
    );

endinterface

// File: rtl/canvas_arbiter.sv
// Arbitrates the single-port canvas RAM between the pen, the wipe sweep and the recognizer.
// state | meaning: IDLE pen owns RAM | CLEAR zero sweep | START kick recognizer | RECOG wait result
module canvas_arbiter
    import canvas_pkg::*;
#(
    parameter int ADDR_W  = CANVAS_ADDR_W,
    parameter int TIMEOUT = REC_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    canvas_arbiter_if.slave  bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [REC_DATA_W-1:0]   result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    timeout_err_q, timeout_err_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            clr_cnt_q      <= '0;
            tmo_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            tmo_q          <= tmo_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        tmo_d          = tmo_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_err_d  = timeout_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (bus.submit) begin
                    state_d       = ST_START;
                    tmo_d         = '0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_RECOG;
            end
            ST_RECOG: begin
                // The counter holds the number of RECOG cycles completed, so it
                // reaches TIMEOUT on the last permitted cycle and never wraps.
                tmo_d = tmo_q + 1'b1;
                if (bus.rec_ready) begin
                    result_d       = bus.rec_data;
                    result_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end else if (tmo_d == TMO_LIMIT) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_addr      = bus.draw_addr;
        bus.mem_we        = 1'b0;
        bus.mem_wdata     = 1'b0;
        bus.draw_ack      = 1'b0;
        bus.end_write     = 1'b0;
        bus.rec_read_data = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.mem_addr  = bus.draw_addr;
                bus.mem_wdata = bus.draw_data;
                bus.mem_we    = bus.draw_req & rst;
                bus.draw_ack  = bus.draw_req & rst;
            end
            ST_CLEAR: begin
                bus.mem_addr = clr_cnt_q;
                bus.mem_we   = rst;
            end
            ST_START: begin
                bus.mem_addr      = bus.rec_read_addr;
                bus.end_write     = rst;
                bus.rec_read_data = bus.mem_rdata;
            end
            ST_RECOG: begin
                bus.mem_addr      = bus.rec_read_addr;
                bus.rec_read_data = bus.mem_rdata;
            end
            default: begin
                bus.mem_addr = bus.draw_addr;
            end
        endcase
    end

    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: doc/canvas_arbiter.md
CANVAS_ARBITER -- requirements
Module: canvas_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: canvas address width, giving 1024 one-bit pixels on a 32x32 grid.
REQ-002 SHALL have parameter TIMEOUT, default 2047: the maximum number of RECOG cycles to wait for a result.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  system clock; all logic on posedge.
REQ-005 rst  in  1  synchronous reset, active-low.
REQ-006 draw_req  in  1  pen requests a pixel write.
REQ-007 draw_addr  in  10  pixel address; bits [9:5] are the row, bits [4:0] the column.
REQ-008 draw_data  in  1  pixel value.
REQ-009 draw_ack  out  1  write accepted this cycle.
REQ-010 submit  in  1  user requests recognition.
REQ-011 clear_req  in  1  user requests a canvas wipe.
REQ-012 end_write  out  1  one-cycle start pulse to the recognizer.
REQ-013 rec_read_enable  in  1  recognizer read strobe.
REQ-014 rec_read_addr  in  10  recognizer read address.
REQ-015 rec_read_data  out  1  pixel returned to the recognizer.
REQ-016 rec_ready  in  1  recognizer result valid.
REQ-017 rec_data  in  8  recognized character code.
REQ-018 mem_addr  out  10  canvas RAM address (RAM read is asynchronous, write is synchronous).
REQ-019 mem_we  out  1  RAM write enable.
REQ-020 mem_wdata  out  1  RAM write data.
REQ-021 mem_rdata  in  1  RAM read data.
REQ-022 busy  out  1  high in any state other than IDLE.
REQ-023 result  out  8  last recognized code.
REQ-024 result_valid  out  1  one-cycle pulse when result updates.
REQ-025 timeout_err  out  1  sticky flag; cleared by reset or by the next submit.

Function
REQ-026 SHALL implement states IDLE, CLEAR, START and RECOG.
REQ-027 IDLE SHALL forward the draw port to RAM: mem_addr=draw_addr, mem_wdata=draw_data, mem_we=draw_ack=draw_req.
REQ-028 IDLE, with clear_req=1, SHALL go to CLEAR next cycle, and clear_req SHALL take priority over submit.
REQ-029 IDLE, with submit=1 and clear_req=0, SHALL go to START next cycle; a draw write in that same cycle SHALL still complete.
REQ-030 CLEAR SHALL write 0 to address clr_cnt (10-bit, starting at 0), incrementing by 1 per cycle.
REQ-031 CLEAR SHALL return to IDLE after writing address 1023, taking exactly 1024 cycles.
REQ-032 START SHALL last exactly one cycle: end_write=1, mem_addr=rec_read_addr, mem_we=0; then go to RECOG.
REQ-033 RECOG SHALL drive mem_addr=rec_read_addr and mem_we=0, and SHALL increment a timeout counter each cycle.
REQ-034 In START and RECOG, rec_read_data SHALL equal mem_rdata combinationally (zero latency), so the pixel is valid in the same cycle as rec_read_addr.
REQ-035 Outside START and RECOG, rec_read_data SHALL be 0.
REQ-036 RECOG, with rec_ready=1, SHALL load result<=rec_data and pulse result_valid for one cycle, then go to IDLE.
REQ-037 RECOG, when the timeout counter equals TIMEOUT and rec_ready=0, SHALL set timeout_err, leave result unchanged, and go to IDLE.
REQ-038 If rec_ready and timeout coincide, rec_ready SHALL win.
REQ-039 Outside IDLE, draw_ack SHALL be 0; the requester holds its request.
REQ-040 Outside IDLE, submit and clear_req SHALL be ignored and not queued.
REQ-041 rec_ready outside RECOG SHALL be ignored.
REQ-042 end_write SHALL be asserted only in START, exactly once per accepted submit.
REQ-043 The timeout counter SHALL be 11-bit, cleared on entry to START, with no wrap (the state exits first).

Reset
REQ-044 When rst=0 at posedge, the block SHALL go to IDLE and set clr_cnt=0, timeout counter=0, result=8'd0, result_valid=0, timeout_err=0, end_write=0.
REQ-045 Reset in CLEAR or RECOG SHALL abort immediately; a partially cleared canvas is acceptable.
REQ-046 During reset, mem_we and draw_ack SHALL be 0.

Structure
REQ-047 Package canvas_pkg SHALL hold CANVAS_ADDR_W=10, CANVAS_PIXELS=1024, REC_TIMEOUT=2047 and the state enum type.
REQ-048 The block SHALL have no sub-module; the RAM is external.
REQ-049 The mux/FSM SHALL be kept in one module.

Verification
REQ-050 Reset, then draw_req=1, draw_addr=10'h21, draw_data=1 in IDLE -> draw_ack=1, mem_we=1, mem_addr=10'h21 in the same cycle.
REQ-051 clear_req and submit both high in IDLE -> CLEAR; mem_we=1 for exactly 1024 cycles at addresses 0..1023, end_write never pulses; back to IDLE.
REQ-052 submit, with a model recognizer reading 1024 pixels, then rec_ready=1 with rec_data=8'd65 -> end_write pulses once; every rec_read_data matches RAM; result=65, result_valid one cycle, busy drops.
REQ-053 submit with a silent recognizer -> timeout_err=1 after 2047 RECOG cycles, result unchanged, IDLE; the next submit clears timeout_err.
REQ-054 draw_req held during RECOG -> draw_ack=0 and no RAM writes; in the first IDLE cycle the write completes.
REQ-055 rst=0 in mid-CLEAR at clr_cnt=500 -> next cycle IDLE, mem_we=0, all outputs at reset values.
